// File: rtl/temp_display.sv
// temp_display: converts a binary temperature to three BCD digits using a
// serial shift-add-3 (double dabble) and drives them onto a 3-digit
// multiplexed 7-segment display.
//
// Optional build macro: LEADING_ZERO_BLANK_EN
//   defined   -> leading zero digits are blanked on the display
//   undefined -> all three digits are always shown
// The digit_* outputs are the same in both builds; only seg differs.
//
// Handshake: load is sampled on posedge clk only while the converter is idle
// (busy=0 and not in its done cycle); loads at other times are dropped.
// done pulses for one cycle, on the cycle the new digit_* values first
// appear; busy is low on that cycle.
module temp_display #(
    parameter int BIN_W    = 10,
    parameter int SCAN_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [BIN_W-1:0] bin_value,
    output logic             busy,
    output logic             done,
    output logic [3:0]       digit_ones,
    output logic [3:0]       digit_tens,
    output logic [3:0]       digit_huns,
    output logic [2:0]       an,
    output logic [6:0]       seg
);

    localparam int CNT_W  = $clog2(BIN_W + 1);
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SR_W   = 12 + BIN_W;

    localparam logic [BIN_W-1:0]  MAX_VAL    = BIN_W'(999);
    localparam logic [CNT_W-1:0]  LAST_SHIFT = CNT_W'(BIN_W - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Control strobes decoded from the FSM
    logic capture;
    logic shift_en;
    logic finish;

    // Conversion datapath
    logic [BIN_W-1:0] bin_reg;
    logic [11:0]      bcd_reg;
    logic [CNT_W-1:0] shift_cnt;
    logic [11:0]      bcd_adj;
    logic [SR_W-1:0]  sr_shifted;
    logic [BIN_W-1:0] bin_sat;

    // Display scan
    logic [SCAN_W-1:0] scan_cnt;
    logic [3:0]        sel_digit;
    logic              blank;

    // Segment decode for one BCD digit, active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = 7'b1111111;
        endcase
        return p;
    endfunction

    // Conversion FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Conversion FSM next-state and control strobes
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        shift_en   = 1'b0;
        finish     = 1'b0;
        case (state)
            S_IDLE: begin
                if (load) begin
                    capture    = 1'b1;
                    state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shift_en = 1'b1;
                if (shift_cnt == LAST_SHIFT) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                finish     = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Saturate the input so the result always fits three BCD digits
    always_comb begin
        bin_sat = (bin_value > MAX_VAL) ? MAX_VAL : bin_value;
    end

    // Add-3 correction on every nibble >= 5, then one left shift of {bcd,bin}
    always_comb begin
        bcd_adj = bcd_reg;
        for (int i = 0; i < 3; i++) begin
            if (bcd_reg[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_reg[i*4 +: 4] + 4'd3;
            end
        end
        sr_shifted = {bcd_adj, bin_reg} << 1;
    end

    // Conversion datapath and visible digit registers; digits only change in DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_reg    <= '0;
            bcd_reg    <= '0;
            shift_cnt  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            digit_ones <= 4'd0;
            digit_tens <= 4'd0;
            digit_huns <= 4'd0;
        end else begin
            done <= finish;
            if (capture) begin
                bin_reg   <= bin_sat;
                bcd_reg   <= '0;
                shift_cnt <= '0;
                busy      <= 1'b1;
            end
            if (shift_en) begin
                bcd_reg   <= sr_shifted[SR_W-1:BIN_W];
                bin_reg   <= sr_shifted[BIN_W-1:0];
                shift_cnt <= shift_cnt + 1'b1;
            end
            if (finish) begin
                digit_ones <= bcd_reg[3:0];
                digit_tens <= bcd_reg[7:4];
                digit_huns <= bcd_reg[11:8];
                busy       <= 1'b0;
            end
        end
    end

    // Free-running scan divider; rotates the digit select on each wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            an       <= 3'b001;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            an       <= {an[1:0], an[2]};
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Pick the selected digit and decide whether it is blanked
    always_comb begin
        sel_digit = digit_ones;
        blank     = 1'b0;
        case (an)
            3'b010:  sel_digit = digit_tens;
            3'b100:  sel_digit = digit_huns;
            default: sel_digit = digit_ones;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        if (an == 3'b100 && digit_huns == 4'd0) begin
            blank = 1'b1;
        end
        if (an == 3'b010 && digit_huns == 4'd0 && digit_tens == 4'd0) begin
            blank = 1'b1;
        end
`endif
    end

    // Segment drive for the selected digit
    always_comb begin
        seg = blank ? 7'b1111111 : seg_decode(sel_digit);
    end

endmodule

// File: tb/tb_temp_display.sv
// Directed bench for temp_display (BIN_W=10, SCAN_DIV=4).
module tb_temp_display;

    localparam int BIN_W    = 10;
    localparam int SCAN_DIV = 4;

    logic             clk;
    logic             rst;
    logic             load;
    logic [BIN_W-1:0] bin_value;
    logic             busy;
    logic             done;
    logic [3:0]       digit_ones;
    logic [3:0]       digit_tens;
    logic [3:0]       digit_huns;
    logic [2:0]       an;
    logic [6:0]       seg;

    int n_checks = 0;
    int n_err    = 0;
    int done_cnt = 0;

    // expected {huns,tens,ones} per accepted load
    logic [11:0] exp_q[$];
    logic [11:0] e_mon;

    temp_display #(
        .BIN_W   (BIN_W),
        .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .bin_value (bin_value),
        .busy      (busy),
        .done      (done),
        .digit_ones(digit_ones),
        .digit_tens(digit_tens),
        .digit_huns(digit_huns),
        .an        (an),
        .seg       (seg)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] pat(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0: p = 7'b1000000;  4'd1: p = 7'b1111001;
            4'd2: p = 7'b0100100;  4'd3: p = 7'b0110000;
            4'd4: p = 7'b0011001;  4'd5: p = 7'b0010010;
            4'd6: p = 7'b0000010;  4'd7: p = 7'b1111000;
            4'd8: p = 7'b0000000;  4'd9: p = 7'b0010000;
            default: p = 7'b1111111;
        endcase
        return p;
    endfunction

    // expected seg for digits e={huns,tens,ones} with select sel
    function automatic logic [6:0] exp_seg(input logic [11:0] e, input logic [2:0] sel);
        logic [6:0] p;
        if (sel == 3'b100) p = pat(e[11:8]);
        else if (sel == 3'b010) p = pat(e[7:4]);
        else p = pat(e[3:0]);
`ifdef LEADING_ZERO_BLANK_EN
        if (sel == 3'b100 && e[11:8] == 4'd0) p = 7'b1111111;
        if (sel == 3'b010 && e[11:8] == 4'd0 && e[7:4] == 4'd0) p = 7'b1111111;
`endif
        return p;
    endfunction

    // scoreboard: every done pulse must match the oldest expected result
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                e_mon = exp_q.pop_front();
                check("digits", {20'd0, digit_huns, digit_tens, digit_ones}, {20'd0, e_mon});
                check("seg_on_done", {25'd0, seg}, {25'd0, exp_seg(e_mon, an)});
                check("busy_on_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    // driver: one-cycle load pulse; returns on the negedge after the load edge
    task automatic start_conv(input logic [BIN_W-1:0] v, input logic [11:0] exp_digits);
        @(negedge clk);
        bin_value = v;
        load      = 1'b1;
        exp_q.push_back(exp_digits);
        @(negedge clk);
        load = 1'b0;
    endtask

    // waits for done; cyc0 = load-edge cycles already elapsed; done expected after edge 11
    task automatic wait_done(input string tag, input int cyc0);
        int cyc;
        cyc = cyc0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done) break;
        end
        check(tag, cyc, 11);
    endtask

    task automatic wait_an(input logic [2:0] target);
        int i;
        for (i = 0; i < 16; i++) begin
            if (an == target) break;
            @(negedge clk);
        end
        check("an_reach", {29'd0, an}, {29'd0, target});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int base;
        logic [2:0] cur;
        int cnt;
        rst       = 1'b1;
        load      = 1'b0;
        bin_value = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        // reset state
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_digits", {20'd0, digit_huns, digit_tens, digit_ones}, 32'h000);
        check("rst_an", {29'd0, an}, 32'b001);
        check("rst_seg", {25'd0, seg}, 32'b1000000);

        // basic conversions and saturation boundaries
        start_conv(10'd427, 12'h427);
        check("busy_running", {31'd0, busy}, 32'd1);
        wait_done("lat_427", 0);
        start_conv(10'd1023, 12'h999);
        wait_done("lat_1023", 0);
        start_conv(10'd1000, 12'h999);
        wait_done("lat_1000", 0);
        start_conv(10'd0, 12'h000);
        wait_done("lat_0", 0);
        start_conv(10'd999, 12'h999);
        wait_done("lat_999", 0);
        start_conv(10'd58, 12'h058);
        wait_done("lat_58", 0);
        start_conv(10'd999, 12'h999);
        wait_done("lat_999b", 0);
        idle(2);

        // load while busy is dropped; digits hold until done
        base = done_cnt;
        start_conv(10'd427, 12'h427);
        idle(4);
        check("hold_digits", {20'd0, digit_huns, digit_tens, digit_ones}, 32'h999);
        check("busy_mid", {31'd0, busy}, 32'd1);
        bin_value = 10'd100;
        load      = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_done("lat_ignored", 5);
        idle(15);
        check("one_done", done_cnt - base, 1);
        check("busy_after", {31'd0, busy}, 32'd0);

        // scan rotation and per-digit segments with 4/2/7 showing
        cur = an;
        cnt = 0;
        while (an == cur && cnt < 8) begin
            @(negedge clk);
            cnt++;
        end
        check("scan_rot0", {29'd0, an}, {29'd0, cur[1:0], cur[2]});
        for (int ph = 0; ph < 3; ph++) begin
            check("scan_seg", {25'd0, seg}, {25'd0, exp_seg(12'h427, an)});
            cur = an;
            cnt = 0;
            while (an == cur && cnt < 10) begin
                @(negedge clk);
                cnt++;
            end
            check("scan_period", cnt, SCAN_DIV);
            check("scan_rot", {29'd0, an}, {29'd0, cur[1:0], cur[2]});
        end
        wait_an(3'b100);
        check("seg_huns4", {25'd0, seg}, 32'b0011001);
        wait_an(3'b010);
        check("seg_tens2", {25'd0, seg}, 32'b0100100);
        wait_an(3'b001);
        check("seg_ones7", {25'd0, seg}, 32'b1111000);

        // leading zeros: value 7
        start_conv(10'd7, 12'h007);
        wait_done("lat_7", 0);
        wait_an(3'b100);
`ifdef LEADING_ZERO_BLANK_EN
        check("lz_huns", {25'd0, seg}, 32'b1111111);
`else
        check("lz_huns", {25'd0, seg}, 32'b1000000);
`endif
        wait_an(3'b010);
`ifdef LEADING_ZERO_BLANK_EN
        check("lz_tens", {25'd0, seg}, 32'b1111111);
`else
        check("lz_tens", {25'd0, seg}, 32'b1000000);
`endif
        wait_an(3'b001);
        check("lz_ones", {25'd0, seg}, 32'b1111000);

        // reset in the middle of a conversion
        base = done_cnt;
        start_conv(10'd427, 12'h427);
        idle(6);
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_digits", {20'd0, digit_huns, digit_tens, digit_ones}, 32'h000);
        check("mid_rst_an", {29'd0, an}, 32'b001);
        check("mid_rst_seg", {25'd0, seg}, 32'b1000000);
        @(negedge clk);
        rst = 1'b0;
        idle(20);
        check("mid_rst_no_done", done_cnt - base, 0);
        check("mid_rst_busy_after", {31'd0, busy}, 32'd0);

        // converter usable again after the abort
        start_conv(10'd305, 12'h305);
        wait_done("lat_305", 0);
        idle(2);
        check("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
